// File: rtl/lif_neuron_core.sv
// Leaky integrate-and-fire neuron that sits behind the synaptic weight RAM and emits AER spike requests.
// Build option: define SPIKE_COUNT_EN to include the saturating accepted-spike counter on spike_count.
module lif_neuron_core #(
  parameter logic [3:0] NEURON_ID     = 4'd5,
  parameter int         V_WIDTH       = 16,
  parameter int         THRESHOLD     = 1000,
  parameter int         LEAK_PERIOD   = 16,
  parameter int         LEAK_AMOUNT   = 1,
  parameter int         REFRAC_CYCLES = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ev_valid,
  input  logic signed [10:0]        weight_in,
  input  logic                      aer_ack,
  output logic                      aer_req,
  output logic [3:0]                aer_addr,
  output logic signed [V_WIDTH-1:0] v_mem,
  output logic                      busy,
  output logic [15:0]               spike_count
);

  localparam int LCW = (LEAK_PERIOD > 1) ? $clog2(LEAK_PERIOD) : 1;
  localparam int RCW = (REFRAC_CYCLES > 0) ? $clog2(REFRAC_CYCLES + 1) : 1;

  localparam logic signed [V_WIDTH-1:0] LEAK_V   = V_WIDTH'(LEAK_AMOUNT);
  localparam logic signed [V_WIDTH-1:0] THRESH_V = V_WIDTH'(THRESHOLD);
  localparam logic signed [V_WIDTH-1:0] V_MAX    = {1'b0, {(V_WIDTH-1){1'b1}}};
  localparam logic signed [V_WIDTH-1:0] V_MIN    = {1'b1, {(V_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_INTEGRATE = 2'd0,
    ST_FIRE      = 2'd1,
    ST_REFRACT   = 2'd2
  } state_t;

  state_t                     state_q, state_d;
  logic signed [V_WIDTH-1:0]  v_q, v_d;
  logic                       req_q, req_d;
  logic [3:0]                 addr_q, addr_d;
  logic [RCW-1:0]             refrac_q, refrac_d;
  logic [LCW-1:0]             leak_cnt_q, leak_cnt_d;
  logic                       pend_q;

  logic                       leak_tick;
  logic signed [V_WIDTH-1:0]  v_leak;
  logic signed [V_WIDTH:0]    v_sum;
  logic signed [V_WIDTH-1:0]  v_sat;
  logic signed [V_WIDTH-1:0]  v_int;

  // Free-running leak timer; runs regardless of neuron state.
  always_comb begin
    leak_tick  = (leak_cnt_q == LCW'(LEAK_PERIOD - 1));
    leak_cnt_d = leak_tick ? '0 : leak_cnt_q + LCW'(1);
  end

  // Leak moves toward zero and stops there rather than crossing sign.
  always_comb begin
    v_leak = v_q;
    if (leak_tick) begin
      if (v_q > LEAK_V) begin
        v_leak = v_q - LEAK_V;
      end else if (v_q < -LEAK_V) begin
        v_leak = v_q + LEAK_V;
      end else begin
        v_leak = '0;
      end
    end
  end

  always_comb begin
    v_sum = $signed({v_leak[V_WIDTH-1], v_leak}) +
            $signed({{(V_WIDTH-10){weight_in[10]}}, weight_in});
    v_sat = v_sum[V_WIDTH-1:0];
    if (v_sum[V_WIDTH] != v_sum[V_WIDTH-1]) begin
      v_sat = v_sum[V_WIDTH] ? V_MIN : V_MAX;
    end
    v_int = pend_q ? v_sat : v_leak;
  end

  always_comb begin
    state_d  = state_q;
    v_d      = v_q;
    req_d    = req_q;
    addr_d   = addr_q;
    refrac_d = refrac_q;
    case (state_q)
      ST_INTEGRATE: begin
        if (v_int >= THRESH_V) begin
          v_d     = '0;
          req_d   = 1'b1;
          addr_d  = NEURON_ID;
          state_d = ST_FIRE;
        end else begin
          v_d = v_int;
        end
      end
      ST_FIRE: begin
        v_d = '0;
        if (aer_ack) begin
          req_d    = 1'b0;
          addr_d   = 4'd0;
          refrac_d = RCW'(REFRAC_CYCLES);
          state_d  = (REFRAC_CYCLES == 0) ? ST_INTEGRATE : ST_REFRACT;
        end
      end
      ST_REFRACT: begin
        v_d      = '0;
        refrac_d = refrac_q - RCW'(1);
        if (refrac_q <= RCW'(1)) begin
          state_d = ST_INTEGRATE;
        end
      end
      default: begin
        state_d = ST_INTEGRATE;
        v_d     = '0;
        req_d   = 1'b0;
        addr_d  = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_INTEGRATE;
      v_q        <= '0;
      req_q      <= 1'b0;
      addr_q     <= 4'd0;
      refrac_q   <= '0;
      leak_cnt_q <= '0;
      pend_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      v_q        <= v_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
      refrac_q   <= refrac_d;
      leak_cnt_q <= leak_cnt_d;
      pend_q     <= ev_valid;
    end
  end

  assign aer_req  = req_q;
  assign aer_addr = addr_q;
  assign v_mem    = v_q;
  assign busy     = (state_q != ST_INTEGRATE);

`ifdef SPIKE_COUNT_EN
  logic        hs_accept;
  logic [15:0] spike_cnt_q;

  assign hs_accept = (state_q == ST_FIRE) && aer_ack;

  always_ff @(posedge clk) begin
    if (rst) begin
      spike_cnt_q <= 16'd0;
    end else if (hs_accept && (spike_cnt_q != 16'hFFFF)) begin
      spike_cnt_q <= spike_cnt_q + 16'd1;
    end
  end

  assign spike_count = spike_cnt_q;
`else
  assign spike_count = 16'd0;
`endif

endmodule
